data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Data-memory controller on the CPU's MEM-stage data port. Consumes the address, write data, memwrite/memread strobes and 4-bit sign mask that the CPU drives from EX/MEM. Produces the load word the CPU registers into MEM/WB.
- Bridges to a single-port, word-wide, 1-cycle-latency synchronous SRAM (BRAM).
- Performs sub-word load extraction with sign/zero extension, and read-modify-write (RMW) for byte/halfword stores.
- Drives a busy/stall signal for the pipeline hazard logic and flags misaligned accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit SRAM words (power of two)
- AW, 10, SRAM word-address width, equal to log2(DEPTH_WORDS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  byte address from CPU
- wr_data  in  32  store data, right-aligned
- memwrite  in  1  store request, sampled in IDLE
- memread  in  1  load request, sampled in IDLE
- sign_mask  in  4  [2:0] size: 001 byte, 011 half, 111 word; [3]=1 zero-extend (LBU/LHU)
- rd_data  out  32  extended load result, registered
- rd_valid  out  1  one-cycle pulse, rd_data updated
- busy  out  1  controller not accepting requests; pipeline must stall
- misaligned  out  1  one-cycle pulse, request dropped
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  AW  word address = addr[AW+1:2]
- sram_wdata  out  32  SRAM write word
- sram_rdata  in  32  SRAM read word, valid the cycle after sram_en with sram_we=0

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - rd_data=0, rd_valid=0, busy=0, misaligned=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - Asserting reset mid-operation aborts it immediately. No partial SRAM write may occur after rst_n falls.
- Request capture (IDLE only):
  - addr, wr_data, sign_mask and the request type are latched on the accept edge.
  - Requests are ignored while busy=1. The CPU holds its request until busy=0.
- Priority: memwrite and memread both 1 -> treated as a store; the read is dropped.
- Alignment:
  - Half with addr[0]=1 -> misaligned.
  - Word with addr[1:0]!=0 -> misaligned.
  - A misaligned request pulses misaligned for 1 cycle, causes no SRAM activity, leaves rd_valid=0, and stays in IDLE.
- Addresses beyond DEPTH_WORDS wrap: upper bits above addr[AW+1] are ignored.
- Undefined size codes (000, 010, 1xx with [2:0] not 111) are treated as word.
- FSM states: IDLE, LD_WAIT, RMW_WAIT, RMW_WR.
  - IDLE + load: sram_en=1, sram_we=0 combinationally in the accept cycle -> LD_WAIT. busy=1 from the next cycle.
  - LD_WAIT: lane select by addr[1:0] and size; sign-extend unless sign_mask[3]=1 (word ignores [3]). Register into rd_data with rd_valid=1 -> IDLE.
    - Load latency: accept edge N, rd_valid high in cycle N+2.
  - IDLE + word store: sram_en=1, sram_we=1, sram_wdata=wr_data in the accept cycle. Stays IDLE, busy never asserts. Single-cycle.
  - IDLE + byte/half store: sram_en=1, sram_we=0 -> RMW_WAIT.
  - RMW_WAIT: merge the latched wr_data low byte or half into sram_rdata at lane addr[1:0]; register the merged word -> RMW_WR.
  - RMW_WR: sram_en=1, sram_we=1, sram_wdata=merged word -> IDLE.
    - busy=1 in RMW_WAIT and RMW_WR. The store completes 3 cycles after accept.
- Lane mapping is little-endian:
  - Byte lane k = bits [8k+7:8k].
  - Half lane 0 = [15:0], half lane 1 = [31:16].
- rd_data holds its value between loads; rd_valid is only a strobe.
- busy is registered and glitch-free. No request is lost when it arrives on the cycle busy falls, because the FSM is in IDLE that cycle.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings: SZ_BYTE=3'b001, SZ_HALF=3'b011, SZ_WORD=3'b111.
  - Bit index SM_UNSIGNED=3.
  - FSM state enum.
- One natural combinational sub-module, lane_extract, shared between the load path and the RMW merge:
  - Inputs: word, byte offset, size, unsigned flag.
  - Outputs: the extended value, and the merged word given the store data.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then LW 0x10 -> store single-cycle with busy=0; rd_data=0xDEADBEEF, rd_valid at accept+2.
- Memory word 0x11223344 at 0x20, SB 0xAA to 0x22 -> RMW, busy for 2 cycles, SRAM word becomes 0x11AA3344. LBU 0x22 -> 0x000000AA; LB 0x22 -> 0xFFFFFFAA.
- SH 0x8001 to 0x26 -> upper half replaced. LH 0x26 -> 0xFFFF8001; LHU 0x26 -> 0x00008001.
- LW at 0x31 and SH at 0x33 -> misaligned pulse each; sram_en never asserts; memory unchanged; rd_valid stays 0.
- memread=memwrite=1 at 0x40 with wr_data=0x5 (word) -> treated as store; word = 0x5; no rd_valid.
- Assert rst_n=0 during RMW_WAIT of an SB -> sram_we=0 immediately; target word unchanged; after release state IDLE, busy=0, rd_data=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and request-decoding helpers for the data-memory controller.
package mem_pkg;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  localparam int unsigned SM_UNSIGNED = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLdWait,
    StRmwWait,
    StRmwWr
  } mem_state_e;

  // Any size code other than byte/half behaves as a full word.
  function automatic logic [2:0] norm_size(input logic [2:0] sz);
    return (sz == SZ_BYTE || sz == SZ_HALF) ? sz : SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lane_extract.sv
// Little-endian lane logic: extends a byte/half/word out of a memory word and merges store data
// into it at the same lane.
module lane_extract
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
    ext_o    = word_i;
    merged_o = store_data_i;
    unique case (size_i)
      SZ_BYTE: begin
        ext_o    = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged_o = word_i;
        merged_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
      end
      SZ_HALF: begin
        ext_o    = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged_o = word_i;
        merged_o[{offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      end
      default: begin
        ext_o    = word_i;
        merged_o = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: loads with sub-word extension, single-cycle word stores and
// read-modify-write byte/half stores against a 1-cycle-latency synchronous SRAM.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [3:0]    sign_mask,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          misaligned,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  mem_state_e state_q, state_d;

  logic [AW-1:0] waddr_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q, merged_q, rd_data_q;
  logic          rd_valid_q, busy_q, mis_q;

  logic [2:0]  req_size;
  logic        req, req_mis, accept;
  logic [31:0] ext_val, merged_val;

  // Address bits above the SRAM window are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign req_size = norm_size(sign_mask[2:0]);
  assign req_mis  = is_misaligned(req_size, addr[1:0]);
  assign req      = memwrite | memread;
  // Gate with rst_n so no SRAM strobe can leak out while reset is held.
  assign accept   = rst_n && (state_q == StIdle) && req && !req_mis;

  lane_extract u_lane_extract (
    .word_i       (sram_rdata),
    .offset_i     (off_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .store_data_i (wdata_q),
    .ext_o        (ext_val),
    .merged_o     (merged_val)
  );

  always_comb begin
    state_d    = state_q;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = waddr_q;
    sram_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sram_en   = 1'b1;
          sram_addr = addr[AW+1:2];
          if (memwrite && req_size == SZ_WORD) begin
            sram_we    = 1'b1;
            sram_wdata = wr_data;
          end else if (memwrite) begin
            state_d = StRmwWait;
          end else begin
            state_d = StLdWait;
          end
        end
      end
      StLdWait:  state_d = StIdle;
      StRmwWait: state_d = StRmwWr;
      StRmwWr: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_wdata = merged_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      waddr_q    <= '0;
      off_q      <= 2'b00;
      size_q     <= SZ_WORD;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != StIdle);
      mis_q      <= (state_q == StIdle) && req && req_mis;
      rd_valid_q <= (state_q == StLdWait);
      if (accept) begin
        waddr_q <= addr[AW+1:2];
        off_q   <= addr[1:0];
        size_q  <= req_size;
        uns_q   <= sign_mask[SM_UNSIGNED];
        wdata_q <= wr_data;
      end
      if (state_q == StLdWait) rd_data_q <= ext_val;
      if (state_q == StRmwWait) merged_q <= merged_val;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign misaligned = mis_q;

endmodule
